// File: rtl/mux_arbiter.sv
// Round-robin arbiter that steers a 4-input registered mux.
// It accounts for the mux's one-cycle register latency and caps each grant with a hold limit.
module mux_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] gnt,
   output logic [1:0] set,
   output logic       saida_valid,
   output logic       busy,
   output logic       timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [1:0]        r_state;
   logic [3:0]        r_gnt;
   logic [1:0]        r_set;
   logic              r_valid;
   logic              r_timeout;
   logic [1:0]        r_ptr;
   logic [HOLD_W-1:0] r_hold;

   logic [7:0]        w_reqDup;
   logic [3:0]        w_reqRot;
   logic [1:0]        w_offset;
   logic [1:0]        w_winner;
   logic              w_release;
   logic              w_limit;

   // Rotate req so that bit 0 is the requester at r_ptr; the first set bit wins.
   assign w_reqDup = {req, req};
   assign w_reqRot = 4'(w_reqDup >> r_ptr);

   always_comb begin
      w_offset = 2'd3;
      if (w_reqRot[0])
         w_offset = 2'd0;
      else if (w_reqRot[1])
         w_offset = 2'd1;
      else if (w_reqRot[2])
         w_offset = 2'd2;
   end

   assign w_winner  = r_ptr + w_offset;
   assign w_release = done[r_set] | ~req[r_set];
   assign w_limit   = (r_hold == HOLD_LAST);

   // The release that ends a grant wins over the hold limit, so timeout flags only forced revocations.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_gnt     <= 4'b0000;
         r_set     <= 2'd0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_ptr     <= 2'd0;
         r_hold    <= '0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  r_state <= S_SETUP;
                  r_gnt   <= 4'b0001 << w_winner;
                  r_set   <= w_winner;
                  r_hold  <= '0;
               end
            end
            S_SETUP: begin
               r_state <= S_HOLD;
               r_valid <= 1'b1;
            end
            S_HOLD: begin
               if (w_release || w_limit) begin
                  r_state   <= S_IDLE;
                  r_gnt     <= 4'b0000;
                  r_valid   <= 1'b0;
                  r_ptr     <= r_set + 2'd1;
                  r_timeout <= ~w_release;
               end else begin
                  r_hold <= r_hold + HOLD_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_gnt   <= 4'b0000;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign gnt         = r_gnt;
   assign set         = r_set;
   assign saida_valid = r_valid;
   assign busy        = (r_state != S_IDLE);
   assign timeout     = r_timeout;

endmodule
